// File: rtl/pixel_stream_pkg.sv
// Shared constants and helpers for the pixel packing datapath.
//   PIX_W        default bits per pixel
//   PIX_PER_WORD default pixels per output beat
//   FRAME_PIXELS default pixels per frame (512x512)
//   WORD_W       default packed word width
//   keep_mask(n) mask with the n lowest bits set (n <= MAX_LANES)
package pixel_stream_pkg;

  localparam int unsigned PIX_W        = 8;
  localparam int unsigned PIX_PER_WORD = 4;
  localparam int unsigned FRAME_PIXELS = 262144;
  localparam int unsigned WORD_W       = PIX_W * PIX_PER_WORD;
  localparam int unsigned MAX_LANES    = 32;

  function automatic logic [MAX_LANES-1:0] keep_mask(input int unsigned n_lanes);
    logic [MAX_LANES-1:0] mask;
    mask = '0;
    for (int unsigned i = 0; i < MAX_LANES; i++) begin
      if (i < n_lanes) mask[i] = 1'b1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/pixel_stream_packer_axis_out_reg.sv
// Single-stage AXI4-Stream output register. Shared with the upstream unpacker.
//   clk, rst                      clock, synchronous active-high reset
//   load, load_data/keep/last     capture a new beat (only when slot_free)
//   tdata/tkeep/tlast/tvalid      registered stream outputs
//   tready                        downstream accept
//   slot_free                     register empty or draining this cycle
module axis_out_reg
  import pixel_stream_pkg::*;
#(
  parameter int unsigned DATA_W = WORD_W,
  parameter int unsigned KEEP_W = PIX_PER_WORD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic [KEEP_W-1:0] load_keep,
  input  logic              load_last,
  output logic [DATA_W-1:0] tdata,
  output logic [KEEP_W-1:0] tkeep,
  output logic              tlast,
  output logic              tvalid,
  input  logic              tready,
  output logic              slot_free
);

  assign slot_free = !tvalid || tready;

  // Payload only changes on load, so it is stable whenever a beat is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      tdata  <= '0;
      tkeep  <= '0;
      tlast  <= 1'b0;
      tvalid <= 1'b0;
    end else if (load) begin
      tdata  <= load_data;
      tkeep  <= load_keep;
      tlast  <= load_last;
      tvalid <= 1'b1;
    end else if (tready) begin
      tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/pixel_stream_packer.sv
// Packs an 8-bit pixel stream into PIX_PER_WORD-lane AXI4-Stream beats, lane 0 = earliest
// pixel in the LSBs. The last beat of each frame carries tlast and a partial tkeep.
//   clk, rst                 clock, synchronous active-high reset
//   inPixel/Valid/Ready      upstream pixel stream
//   m_axis_t*                packed output stream
//   frameDone                one-cycle pulse after the tlast handshake
module pixel_stream_packer
  import pixel_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = pixel_stream_pkg::PIX_W,
  parameter int unsigned PIX_PER_WORD = pixel_stream_pkg::PIX_PER_WORD,
  parameter int unsigned FRAME_PIXELS = pixel_stream_pkg::FRAME_PIXELS
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [DATA_WIDTH-1:0]              inPixel,
  input  logic                               inPixelValid,
  output logic                               inPixelReady,
  output logic [DATA_WIDTH*PIX_PER_WORD-1:0] m_axis_tdata,
  output logic [PIX_PER_WORD-1:0]            m_axis_tkeep,
  output logic                               m_axis_tlast,
  output logic                               m_axis_tvalid,
  input  logic                               m_axis_tready,
  output logic                               frameDone
);

  localparam int unsigned WORD_BITS = DATA_WIDTH * PIX_PER_WORD;
  localparam int unsigned LANE_W    = $clog2(PIX_PER_WORD);
  localparam int unsigned CNT_W     = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(PIX_PER_WORD - 1);
  localparam logic [CNT_W-1:0]  PIX_LAST  = CNT_W'(FRAME_PIXELS - 1);

  logic [LANE_W-1:0]     lane_q;
  logic [CNT_W-1:0]      pix_cnt_q;
  logic [DATA_WIDTH-1:0] acc_q [PIX_PER_WORD-1];
  logic                  frame_done_q;

  logic                    frame_end;
  logic                    closing_next;
  logic                    slot_free;
  logic                    accept;
  logic                    load;
  logic [WORD_BITS-1:0]    word_data;
  logic [PIX_PER_WORD-1:0] word_keep;

  assign frame_end    = (pix_cnt_q == PIX_LAST);
  assign closing_next = (lane_q == LANE_LAST) || frame_end;
  // Only a word-closing pixel needs the output slot; all others go to the accumulator.
  assign inPixelReady = !rst && (!closing_next || slot_free);
  assign accept       = inPixelValid && inPixelReady;
  assign load         = accept && closing_next;
  assign frameDone    = frame_done_q;

  // Outgoing word = lanes below lane_q from the accumulator, incoming pixel at lane_q,
  // zeros above. Stale accumulator contents are masked rather than cleared.
  always_comb begin
    word_data = '0;
    for (int unsigned k = 0; k < PIX_PER_WORD - 1; k++) begin
      if (k < 32'(lane_q)) word_data[k*DATA_WIDTH +: DATA_WIDTH] = acc_q[k];
    end
    word_data[32'(lane_q)*DATA_WIDTH +: DATA_WIDTH] = inPixel;
    word_keep = PIX_PER_WORD'(keep_mask(32'(lane_q) + 32'd1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q       <= '0;
      pix_cnt_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= m_axis_tvalid && m_axis_tready && m_axis_tlast;
      if (accept) begin
        lane_q    <= closing_next ? '0 : lane_q + 1'b1;
        pix_cnt_q <= frame_end ? '0 : pix_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept && !closing_next) begin
      for (int unsigned k = 0; k < PIX_PER_WORD - 1; k++) begin
        if (k == 32'(lane_q)) acc_q[k] <= inPixel;
      end
    end
  end

  axis_out_reg #(
    .DATA_W (WORD_BITS),
    .KEEP_W (PIX_PER_WORD)
  ) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (word_data),
    .load_keep (word_keep),
    .load_last (frame_end),
    .tdata     (m_axis_tdata),
    .tkeep     (m_axis_tkeep),
    .tlast     (m_axis_tlast),
    .tvalid    (m_axis_tvalid),
    .tready    (m_axis_tready),
    .slot_free (slot_free)
  );

endmodule

// File: tb/tb_pixel_stream_packer.sv
// Bench for pixel_stream_packer: five instances with different frame sizes, each driven
// by its own stimulus; expected beats come from a table or a reference model via a queue.
module tb_pixel_stream_packer;

  localparam int NI = 5;
  // 0: 8-pixel frames, 1: 6, 2: default size, 3: 16, 4: 1001
  localparam int unsigned FP [NI] = '{8, 6, 262144, 16, 1001};
  localparam int BUDGET = 40000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] in_pix [NI];
  logic       in_vld [NI];
  logic       trdy   [NI];

  wire [31:0] tdata  [NI];
  wire [3:0]  tkeep  [NI];
  wire        tlast  [NI];
  wire        tvalid [NI];
  wire        in_rdy [NI];
  wire        fdone  [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    pixel_stream_packer #(
      .DATA_WIDTH   (8),
      .PIX_PER_WORD (4),
      .FRAME_PIXELS (FP[g])
    ) u_dut (
      .clk           (clk),
      .rst           (rst),
      .inPixel       (in_pix[g]),
      .inPixelValid  (in_vld[g]),
      .inPixelReady  (in_rdy[g]),
      .m_axis_tdata  (tdata[g]),
      .m_axis_tkeep  (tkeep[g]),
      .m_axis_tlast  (tlast[g]),
      .m_axis_tvalid (tvalid[g]),
      .m_axis_tready (trdy[g]),
      .frameDone     (fdone[g])
    );
  end

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  typedef struct {
    int    test_id;
    beat_t beat;
  } vec_t;

  typedef struct {
    int test_id;
    int sel;
    int npix;
    int exp_fd;
  } run_t;

  vec_t  vecs [$];
  run_t  runs [$];
  beat_t exp_q [$];

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] m_word;
  int          m_lane;
  int unsigned m_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic add_vec(input int id, input logic [31:0] d, input logic [3:0] k, input logic l);
    vec_t v;
    v.test_id   = id;
    v.beat.data = d;
    v.beat.keep = k;
    v.beat.last = l;
    vecs.push_back(v);
  endtask

  task automatic add_run(input int id, input int sel, input int npix, input int exp_fd);
    run_t r;
    r.test_id = id;
    r.sel     = sel;
    r.npix    = npix;
    r.exp_fd  = exp_fd;
    runs.push_back(r);
  endtask

  // Reference packer: lane n mod 4, close on lane 3 or on the frame's last pixel.
  task automatic model_push(input logic [7:0] p, input int unsigned fp);
    beat_t b;
    m_word[m_lane*8 +: 8] = p;
    m_lane++;
    m_cnt++;
    if (m_lane == 4 || m_cnt == fp) begin
      b.data = m_word;
      b.keep = 4'((1 << m_lane) - 1);
      b.last = (m_cnt == fp);
      exp_q.push_back(b);
      m_word = '0;
      m_lane = 0;
      if (m_cnt == fp) m_cnt = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < NI; i++) begin
      in_vld[i] = 1'b0;
      trdy[i]   = 1'b0;
    end
    #1;
    for (int i = 0; i < NI; i++) check($sformatf("reset_ready%0d", i), 64'(in_rdy[i]), 64'd0);
    @(negedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("reset_outputs%0d", i),
            64'({tvalid[i], tlast[i], tkeep[i], tdata[i], fdone[i]}), 64'd0);
    end
    rst = 1'b0;
  endtask

  // Streams npix pixels into instance sel; checks every output beat against exp_q,
  // AXIS payload stability while stalled, and counts frameDone pulses.
  task automatic run_stream(input int sel, input int npix, input logic [7:0] base, input bit rnd,
                            input bit use_model, output int stalls, output int fd);
    int         idx;
    int         cyc;
    int         tail;
    bit         hold_v;
    bit         hold_o;
    bit         vld;
    bit         rdy_d;
    logic [7:0] pix;
    beat_t      held;
    beat_t      act;
    idx = 0; cyc = 0; tail = 0; hold_v = 0; hold_o = 0; vld = 0; pix = '0; held = '0;
    stalls = 0; fd = 0;
    m_word = '0; m_lane = 0; m_cnt = 0;
    while (1) begin
      @(negedge clk);
      if (!hold_v) begin
        vld = (idx < npix) && (!rnd || $urandom_range(1) == 1);
        pix = rnd ? 8'($urandom) : base + 8'(idx);
      end
      rdy_d       = !rnd || ($urandom_range(1) == 1);
      in_vld[sel] = vld;
      in_pix[sel] = pix;
      trdy[sel]   = rdy_d;
      #1;
      act = {tdata[sel], tkeep[sel], tlast[sel]};
      if (hold_o) check("axis_stable", 64'({tvalid[sel], act}), 64'({1'b1, held}));
      hold_o = tvalid[sel] && !rdy_d;
      held   = act;
      if (tvalid[sel] && rdy_d) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_beat at %0t: got %0h, expected no beat", $time, act);
        end else begin
          check("beat", 64'(act), 64'(exp_q.pop_front()));
        end
      end
      if (vld && in_rdy[sel]) begin
        if (use_model) model_push(pix, FP[sel]);
        idx++;
        hold_v = 0;
      end else begin
        if (vld) stalls++;
        hold_v = vld;
      end
      if (fdone[sel]) fd++;
      if (idx == npix && exp_q.size() == 0 && !tvalid[sel]) tail++;
      if (tail >= 3) break;
      cyc++;
      if (cyc > BUDGET) begin
        n_cmp++;
        n_err++;
        $display("FAIL timeout on instance %0d: got %0d pixels and %0d beats pending, expected 0",
                 sel, npix - idx, exp_q.size());
        break;
      end
    end
    in_vld[sel] = 1'b0;
    trdy[sel]   = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    int         stalls;
    int         fd;
    int         acc3;
    logic [7:0] p3;

    rst = 1'b1;
    for (int i = 0; i < NI; i++) begin
      in_pix[i] = '0;
      in_vld[i] = 1'b0;
      trdy[i]   = 1'b0;
    end

    // Expected beats per test, pixels counting up from 0x01 unless noted.
    add_vec(1, 32'h04030201, 4'hF, 1'b0);
    add_vec(1, 32'h08070605, 4'hF, 1'b1);
    add_vec(2, 32'h04030201, 4'hF, 1'b0);
    add_vec(2, 32'h00000605, 4'h3, 1'b1);
    for (int k = 0; k < 8; k++) begin
      add_vec(5, {8'(4*k+4), 8'(4*k+3), 8'(4*k+2), 8'(4*k+1)}, 4'hF, (k == 3) || (k == 7));
    end
    add_vec(4, 32'hA3A2A1A0, 4'hF, 1'b0);

    add_run(1, 0, 8, 1);
    add_run(2, 1, 6, 1);
    add_run(5, 3, 32, 2);

    do_reset();

    // Full-rate table-driven frames; zero stalls means one pixel per cycle.
    foreach (runs[r]) begin
      foreach (vecs[v]) if (vecs[v].test_id == runs[r].test_id) exp_q.push_back(vecs[v].beat);
      run_stream(runs[r].sel, runs[r].npix, 8'h01, 1'b0, 1'b0, stalls, fd);
      check($sformatf("t%0d_frame_done", runs[r].test_id), 64'(fd), 64'(runs[r].exp_fd));
      check($sformatf("t%0d_stalls", runs[r].test_id), 64'(stalls), 64'd0);
    end

    // Reset after 3 pixels of a frame: nothing emitted, next pixel lands in lane 0.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_vld[0] = 1'b1;
      in_pix[0] = 8'h11 + 8'(i);
      trdy[0]   = 1'b1;
      #1;
      check("t4_pre_ready", 64'(in_rdy[0]), 64'd1);
    end
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      trdy[0] = 1'b1;
      #1;
      check("t4_no_beat", 64'(tvalid[0]), 64'd0);
    end
    foreach (vecs[v]) if (vecs[v].test_id == 4) exp_q.push_back(vecs[v].beat);
    run_stream(0, 4, 8'hA0, 1'b0, 1'b0, stalls, fd);
    check("t4_frame_done", 64'(fd), 64'd0);

    // Stall the first beat: three more pixels fit, then ready drops and the beat holds.
    acc3 = 0;
    p3   = 8'h01;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      in_vld[2] = 1'b1;
      in_pix[2] = p3;
      trdy[2]   = 1'b0;
      #1;
      if (c >= 10) begin
        check("t3_hold", 64'({tvalid[2], tkeep[2], tlast[2], tdata[2]}),
              64'({1'b1, 4'hF, 1'b0, 32'h04030201}));
      end
      if (in_rdy[2]) begin
        acc3++;
        p3++;
      end
    end
    check("t3_accepted", 64'(acc3), 64'd7);
    check("t3_ready_low", 64'(in_rdy[2]), 64'd0);
    @(negedge clk);
    trdy[2] = 1'b1;
    #1;
    check("t3_release_ready", 64'(in_rdy[2]), 64'd1);
    @(negedge clk);
    in_vld[2] = 1'b0;
    #1;
    check("t3_second_beat", 64'({tvalid[2], tkeep[2], tlast[2], tdata[2]}),
          64'({1'b1, 4'hF, 1'b0, 32'h08070605}));
    @(negedge clk);
    trdy[2] = 1'b0;

    // Random valid/ready over three 1001-pixel frames against the reference model.
    run_stream(4, 3003, 8'h00, 1'b1, 1'b1, stalls, fd);
    check("t6_frame_done", 64'(fd), 64'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
